// File: rtl/stream_min.sv
// stream_min: per-frame minimum, first-occurrence index and beat count over a valid/ready stream.
// Define STREAM_MIN_MAX_EN to also track the maximum and its first index.
module stream_min #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_len,
`ifdef STREAM_MIN_MAX_EN
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_max_idx,
`endif
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    localparam logic [IDX_W:0] ONE = 1;
    state_t state, state_nx;
    logic [WIDTH-1:0] min_q, min_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic [IDX_W:0]   cnt_q, cnt_nx;
    logic             ovf_q, ovf_nx;
`ifdef STREAM_MIN_MAX_EN
    logic [WIDTH-1:0] max_q, max_nx;
    logic [IDX_W-1:0] mxi_q, mxi_nx;
`endif
    logic take_in, take_out, load;
    assign take_in  = in_valid && in_ready;
    assign take_out = out_valid && out_ready;
    assign load     = state != HOLD && state_nx == HOLD;
    always_comb begin
        state_nx = state;
        min_nx   = min_q;
        idx_nx   = idx_q;
        cnt_nx   = cnt_q;
        ovf_nx   = ovf_q;
`ifdef STREAM_MIN_MAX_EN
        max_nx   = max_q;
        mxi_nx   = mxi_q;
`endif
        if (state == IDLE && take_in) begin
            min_nx   = in_data;
            idx_nx   = '0;
            cnt_nx   = ONE;
            ovf_nx   = 1'b0;
`ifdef STREAM_MIN_MAX_EN
            max_nx   = in_data;
            mxi_nx   = '0;
`endif
            state_nx = in_last ? HOLD : ACCUM;
        end else if (state == ACCUM && take_in) begin
            // once cnt reaches 2^IDX_W further beats are swallowed uncompared
            if (cnt_q[IDX_W]) begin
                ovf_nx = 1'b1;
            end else begin
                if (in_data < min_q) begin
                    min_nx = in_data;
                    idx_nx = cnt_q[IDX_W-1:0];
                end
`ifdef STREAM_MIN_MAX_EN
                if (in_data > max_q) begin
                    max_nx = in_data;
                    mxi_nx = cnt_q[IDX_W-1:0];
                end
`endif
                cnt_nx = cnt_q + ONE;
            end
            state_nx = in_last ? HOLD : ACCUM;
        end else if (state == HOLD && take_out) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            min_q     <= '1;
            idx_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_min   <= '1;
            out_idx   <= '0;
            out_len   <= '0;
            out_ovf   <= 1'b0;
`ifdef STREAM_MIN_MAX_EN
            max_q       <= '0;
            mxi_q       <= '0;
            out_max     <= '0;
            out_max_idx <= '0;
`endif
        end else begin
            state     <= state_nx;
            in_ready  <= state_nx != HOLD;
            out_valid <= state_nx == HOLD;
            min_q     <= min_nx;
            idx_q     <= idx_nx;
            cnt_q     <= cnt_nx;
            ovf_q     <= ovf_nx;
`ifdef STREAM_MIN_MAX_EN
            max_q     <= max_nx;
            mxi_q     <= mxi_nx;
`endif
            // result registers only change when a frame completes
            if (load) begin
                out_min <= min_nx;
                out_idx <= idx_nx;
                out_len <= cnt_nx;
                out_ovf <= ovf_nx;
`ifdef STREAM_MIN_MAX_EN
                out_max     <= max_nx;
                out_max_idx <= mxi_nx;
`endif
            end
        end
    end
endmodule

// File: tb/tb_stream_min.sv
// tb_stream_min: directed checks of stream_min with IDX_W=8 and a parallel IDX_W=2 instance for overflow.
module tb_stream_min;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_ovf;
    logic [7:0] out_min, out_idx;
    logic [8:0] out_len;
    logic       n_in_ready, n_out_valid, n_out_ovf;
    logic [7:0] n_out_min;
    logic [1:0] n_out_idx;
    logic [2:0] n_out_len;
`ifdef STREAM_MIN_MAX_EN
    logic [7:0] out_max, out_max_idx, n_out_max;
    logic [1:0] n_out_max_idx;
`endif
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    stream_min #(.WIDTH(8), .IDX_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_idx(out_idx), .out_len(out_len),
`ifdef STREAM_MIN_MAX_EN
        .out_max(out_max), .out_max_idx(out_max_idx),
`endif
        .out_ovf(out_ovf)
    );

    stream_min #(.WIDTH(8), .IDX_W(2)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_min(n_out_min), .out_idx(n_out_idx), .out_len(n_out_len),
`ifdef STREAM_MIN_MAX_EN
        .out_max(n_out_max), .out_max_idx(n_out_max_idx),
`endif
        .out_ovf(n_out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else pass_cnt++;
    endtask

    // called and returns at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_min", out_min, 8'hff);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", in_ready, 1);

        out_ready = 1'b1;
        send(8'd7, 0); send(8'd3, 0); send(8'd9, 0); send(8'd3, 1);
        chk("f1_valid", out_valid, 1);
        chk("f1_rdy_low", in_ready, 0);
        chk("f1_min", out_min, 3);
        chk("f1_idx", out_idx, 1);
        chk("f1_len", out_len, 4);
        chk("f1_ovf", out_ovf, 0);
        @(negedge clk);
        chk("f1_taken", out_valid, 0);
        chk("f1_rdy_back", in_ready, 1);

        send(8'h42, 1);
        chk("f2_valid", out_valid, 1);
        chk("f2_min", out_min, 8'h42);
        chk("f2_idx", out_idx, 0);
        chk("f2_len", out_len, 1);
`ifdef STREAM_MIN_MAX_EN
        chk("f2_max", out_max, 8'h42);
        chk("f2_max_idx", out_max_idx, 0);
`endif
        @(negedge clk);

        out_ready = 1'b0;
        send(8'd5, 0); idle(2); send(8'd5, 0); idle(1); send(8'd5, 0); idle(3); send(8'd2, 1);
        for (int i = 0; i < 4; i++) begin
            chk("f3_hold_valid", out_valid, 1);
            chk("f3_hold_rdy", in_ready, 0);
            chk("f3_hold_min", out_min, 2);
            chk("f3_hold_idx", out_idx, 3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("f3_released", out_valid, 0);
        chk("f3_rdy_back", in_ready, 1);
        chk("f3_min_kept", out_min, 2);
        chk("f3_len_kept", out_len, 4);

        send(8'd9, 0); send(8'd8, 0); send(8'd7, 0); send(8'd6, 0); send(8'd1, 0); send(8'd0, 1);
        chk("f4n_valid", n_out_valid, 1);
        chk("f4n_rdy", n_in_ready, 0);
        chk("f4n_min", n_out_min, 6);
        chk("f4n_idx", n_out_idx, 3);
        chk("f4n_len", n_out_len, 4);
        chk("f4n_ovf", n_out_ovf, 1);
        chk("f4w_min", out_min, 0);
        chk("f4w_idx", out_idx, 5);
        chk("f4w_len", out_len, 6);
        chk("f4w_ovf", out_ovf, 0);
`ifdef STREAM_MIN_MAX_EN
        chk("f4n_max", n_out_max, 9);
        chk("f4n_max_idx", n_out_max_idx, 0);
`endif
        @(negedge clk);

        send(8'd4, 0); send(8'd2, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", in_ready, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_min", out_min, 8'hff);
        chk("mid_rst_len", out_len, 0);
        chk("mid_rst_ovf_n", n_out_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'd8, 0); send(8'd9, 1);
        chk("f5_valid", out_valid, 1);
        chk("f5_min", out_min, 8);
        chk("f5_idx", out_idx, 0);
        chk("f5_len", out_len, 2);
`ifdef STREAM_MIN_MAX_EN
        chk("f5_max", out_max, 9);
        chk("f5_max_idx", out_max_idx, 1);
`endif
        @(negedge clk);

        send(8'hff, 0); send(8'h00, 1);
        chk("f6_min", out_min, 0);
        chk("f6_idx", out_idx, 1);
        chk("f6_len", out_len, 2);
`ifdef STREAM_MIN_MAX_EN
        chk("f6_max", out_max, 8'hff);
        chk("f6_max_idx", out_max_idx, 0);
`endif
        @(negedge clk);
        chk("f6_taken", out_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
